gpr_write_ctrl: RTL and testbench

GPR_WRITE_CTRL -- requirements
Module: gpr_write_ctrl

---
 rtl/gpr_write_ctrl.sv | 163 ++++++++++++++++
 tb/tb_gpr_write_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_write_ctrl.sv
// gpr_write_ctrl: arbitrates the single GPR write port between the ALU result path
// and a small queue of returning load results.
// - ALU requests are always accepted and win the write port.
// - Load results wait in a DEPTH-entry FIFO and issue only when the ALU is idle.
// - A newer ALU write to a register squashes older queued loads to that register.
// - rs/rt busy flags report pending writes for hazard detection.
// Optional feature: define GPR_WRITE_CTRL_BYPASS_EN to add rs/rt forwarding outputs.
//   With it, an output-stage match is forwarded instead of reported as busy.
module gpr_write_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_num,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_num,
    input  logic [31:0] mem_data,
    output logic        reg_write,
    output logic [4:0]  num_write,
    output logic [31:0] data_write,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    output logic        rs_busy,
    output logic        rt_busy,
`ifdef GPR_WRITE_CTRL_BYPASS_EN
    output logic        rs_fwd_valid,
    output logic        rt_fwd_valid,
    output logic [31:0] rs_fwd_data,
    output logic [31:0] rt_fwd_data,
`endif
    output logic [4:0]  pending
);

    localparam int PTR_W = $clog2(DEPTH);

    // Queue state. Surviving entries are always kept contiguous from rd_ptr,
    // so a squash never leaves a hole and the head is always a live entry.
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]       q_num_q  [DEPTH];
    logic [4:0]       q_num_d  [DEPTH];
    logic [31:0]      q_data_q [DEPTH];
    logic [31:0]      q_data_d [DEPTH];

    // Output stage driving the GPR write port.
    logic        reg_write_q, reg_write_d;
    logic [4:0]  num_write_q, num_write_d;
    logic [31:0] data_write_q, data_write_d;

    logic             alu_go, mem_go, pop;
    logic [4:0]       keep_cnt;
    logic [PTR_W-1:0] src, dst;
    logic             rs_q_hit, rt_q_hit, rs_o_hit, rt_o_hit;

    assign mem_ready  = (count_q < 5'(DEPTH));
    assign pending    = count_q;
    assign reg_write  = reg_write_q;
    assign num_write  = num_write_q;
    assign data_write = data_write_q;

    // Arbitration: ALU first, otherwise the queue head; register 0 is never written.
    always_comb begin
        alu_go       = alu_valid && (alu_num != 5'd0);
        mem_go       = mem_valid && mem_ready && (mem_num != 5'd0);
        pop          = !alu_go && (count_q != 5'd0);
        reg_write_d  = 1'b0;
        num_write_d  = num_write_q;
        data_write_d = data_write_q;
        if (alu_go) begin
            reg_write_d  = 1'b1;
            num_write_d  = alu_num;
            data_write_d = alu_data;
        end else if (pop) begin
            reg_write_d  = 1'b1;
            num_write_d  = q_num_q[rd_ptr_q];
            data_write_d = q_data_q[rd_ptr_q];
        end
    end

    // Queue update: drop the popped head and squashed entries, compact the rest, append the new load.
    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        vld_d    = '0;
        q_num_d  = q_num_q;
        q_data_d = q_data_q;
        keep_cnt = 5'd0;
        src      = '0;
        dst      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            src = rd_ptr_q + PTR_W'(k);
            dst = rd_ptr_d + PTR_W'(keep_cnt);
            if (vld_q[src] && !(pop && (k == 0)) &&
                !(alu_go && (q_num_q[src] == alu_num))) begin
                vld_d[dst]    = 1'b1;
                q_num_d[dst]  = q_num_q[src];
                q_data_d[dst] = q_data_q[src];
                keep_cnt      = keep_cnt + 5'd1;
            end
        end
        // A load arriving with an ALU write to the same register is younger and survives.
        if (mem_go) begin
            dst           = rd_ptr_d + PTR_W'(keep_cnt);
            vld_d[dst]    = 1'b1;
            q_num_d[dst]  = mem_num;
            q_data_d[dst] = mem_data;
            keep_cnt      = keep_cnt + 5'd1;
        end
        count_d = keep_cnt;
    end

    // Hazard query against live queue entries and the output stage.
    always_comb begin
        rs_q_hit = 1'b0;
        rt_q_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (q_num_q[i] == rs)) rs_q_hit = 1'b1;
            if (vld_q[i] && (q_num_q[i] == rt)) rt_q_hit = 1'b1;
        end
        rs_o_hit = reg_write_q && (num_write_q == rs);
        rt_o_hit = reg_write_q && (num_write_q == rt);
`ifdef GPR_WRITE_CTRL_BYPASS_EN
        rs_busy      = (rs != 5'd0) && rs_q_hit;
        rt_busy      = (rt != 5'd0) && rt_q_hit;
        rs_fwd_valid = (rs != 5'd0) && rs_o_hit;
        rt_fwd_valid = (rt != 5'd0) && rt_o_hit;
        rs_fwd_data  = data_write_q;
        rt_fwd_data  = data_write_q;
`else
        rs_busy = (rs != 5'd0) && (rs_q_hit || rs_o_hit);
        rt_busy = (rt != 5'd0) && (rt_q_hit || rt_o_hit);
`endif
    end

    // Control state and the write port, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q     <= '0;
            count_q      <= 5'd0;
            vld_q        <= '0;
            reg_write_q  <= 1'b0;
            num_write_q  <= 5'd0;
            data_write_q <= 32'd0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            vld_q        <= vld_d;
            reg_write_q  <= reg_write_d;
            num_write_q  <= num_write_d;
            data_write_q <= data_write_d;
        end
    end

    // Queue payload; meaningful only where the matching valid bit is set.
    always_ff @(posedge clock) begin
        q_num_q  <= q_num_d;
        q_data_q <= q_data_d;
    end

endmodule

// File: tb/tb_gpr_write_ctrl.sv
// Testbench for gpr_write_ctrl: directed vectors, expected GPR writes held in a
// scoreboard queue and checked by a monitor whenever reg_write is asserted.
module tb_gpr_write_ctrl;

    logic        clock;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_num;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_num;
    logic [31:0] mem_data;
    logic        reg_write;
    logic [4:0]  num_write;
    logic [31:0] data_write;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_busy;
    logic        rt_busy;
    logic [4:0]  pending;
`ifdef GPR_WRITE_CTRL_BYPASS_EN
    logic        rs_fwd_valid;
    logic        rt_fwd_valid;
    logic [31:0] rs_fwd_data;
    logic [31:0] rt_fwd_data;
`endif

    gpr_write_ctrl #(.DEPTH(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .alu_valid    (alu_valid),
        .alu_num      (alu_num),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_num      (mem_num),
        .mem_data     (mem_data),
        .reg_write    (reg_write),
        .num_write    (num_write),
        .data_write   (data_write),
        .rs           (rs),
        .rt           (rt),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
`ifdef GPR_WRITE_CTRL_BYPASS_EN
        .rs_fwd_valid (rs_fwd_valid),
        .rt_fwd_valid (rt_fwd_valid),
        .rs_fwd_data  (rs_fwd_data),
        .rt_fwd_data  (rt_fwd_data),
`endif
        .pending      (pending)
    );

    typedef struct packed {
        logic [4:0]  num;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] n, input logic [31:0] d);
        wr_t e;
        e.num  = n;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic av, input logic [4:0] an, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mn, input logic [31:0] md);
        alu_valid = av;
        alu_num   = an;
        alu_data  = ad;
        mem_valid = mv;
        mem_num   = mn;
        mem_data  = md;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: every write on the GPR port must match the oldest expected write.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && reg_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                         num_write, data_write);
            end else begin
                mon_e = exp_q.pop_front();
                if (num_write !== mon_e.num || data_write !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_order: got reg %0d data 0x%0h, expected reg %0d data 0x%0h",
                             num_write, data_write, mon_e.num, mon_e.data);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        rs = 5'd1;
        rt = 5'd2;
        idle();
        #1 reset_n = 1'b0;
        #1;
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_rs_busy", 32'(rs_busy), 32'd0);
        check("rst_rt_busy", 32'(rt_busy), 32'd0);
        cycle();
        cycle();
        reset_n = 1'b1;
        check("post_rst_mem_ready", 32'(mem_ready), 32'd1);
        check("post_rst_rs_busy", 32'(rs_busy), 32'd0);

        // ALU write with 1-cycle latency, then a write to register 0 is dropped
        push(5'd5, 32'h12345678);
        drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0);
        cycle();
        check("alu_reg_write", 32'(reg_write), 32'd1);
        drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        cycle();
        check("alu_zero_no_write", 32'(reg_write), 32'd0);
        check("hold_num", 32'(num_write), 32'd5);
        check("hold_data", data_write, 32'h12345678);

        // Load to register 0 is discarded
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hF00D);
        cycle();
        check("mem_zero_pending", 32'(pending), 32'd0);
        idle();
        cycle();
        check("mem_zero_no_write", 32'(reg_write), 32'd0);

        // Loads to 1..4 with ALU idle: issue in order, one per cycle
        for (int i = 1; i <= 4; i++) begin
            push(5'(i), 32'h100 + 32'(i));
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + 32'(i));
            cycle();
            check("stream_pending", 32'(pending), 32'd1);
        end
        idle();
        cycle();
        check("stream_drained", 32'(pending), 32'd0);
        cycle();

        // Fill the queue while the ALU owns the port, then drain
        rs = 5'd13;
        rt = 5'd0;
        for (int i = 0; i < 5; i++) push(5'd20, 32'h200 + 32'(i));
        for (int i = 0; i < 4; i++) push(5'(11 + i), 32'h1100 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd20, 32'h200 + 32'(i), 1'b1, 5'(11 + i), 32'h1100 + 32'(i));
            cycle();
            check("fill_pending", 32'(pending), 32'(i + 1));
        end
        check("full_mem_ready", 32'(mem_ready), 32'd0);
        check("full_rs_busy", 32'(rs_busy), 32'd1);
        check("zero_rt_busy", 32'(rt_busy), 32'd0);
        drive(1'b1, 5'd20, 32'h204, 1'b1, 5'd15, 32'hBAD);
        cycle();
        check("full_no_accept", 32'(pending), 32'd4);
        idle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("drain_pending", 32'(pending), 32'(3 - i));
        end
        check("drain_mem_ready", 32'(mem_ready), 32'd1);
        check("drain_rs_free", 32'(rs_busy), 32'd0);
        cycle();

        // WAW squash: queued load to 7 is overwritten by a later ALU write
        push(5'd21, 32'h21);
        push(5'd7, 32'hBBBB);
        drive(1'b1, 5'd21, 32'h21, 1'b1, 5'd7, 32'hAAAA);
        cycle();
        check("squash_pre_pending", 32'(pending), 32'd1);
        drive(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'd0);
        cycle();
        check("squash_pending", 32'(pending), 32'd0);
        idle();
        cycle();
        cycle();

        // Same-cycle load to the ALU's register is younger and survives
        push(5'd7, 32'hCCCC);
        push(5'd7, 32'hDDDD);
        drive(1'b1, 5'd7, 32'hCCCC, 1'b1, 5'd7, 32'hDDDD);
        cycle();
        check("younger_kept", 32'(pending), 32'd1);
        idle();
        cycle();
        check("younger_issued", 32'(pending), 32'd0);
        cycle();

        // Load to 9 held back by three ALU cycles, issues in the fourth
        rs = 5'd9;
        rt = 5'd9;
        push(5'd22, 32'd1);
        push(5'd22, 32'd2);
        push(5'd22, 32'd3);
        push(5'd9, 32'h999);
        drive(1'b1, 5'd22, 32'd1, 1'b1, 5'd9, 32'h999);
        cycle();
        check("hold_rs_busy_1", 32'(rs_busy), 32'd1);
        drive(1'b1, 5'd22, 32'd2, 1'b0, 5'd0, 32'd0);
        cycle();
        check("hold_rs_busy_2", 32'(rs_busy), 32'd1);
        drive(1'b1, 5'd22, 32'd3, 1'b0, 5'd0, 32'd0);
        cycle();
        check("hold_rs_busy_3", 32'(rs_busy), 32'd1);
        check("hold_rt_busy_3", 32'(rt_busy), 32'd1);
        idle();
        cycle();
        check("load9_issue", 32'(reg_write), 32'd1);
        check("load9_num", 32'(num_write), 32'd9);
`ifdef GPR_WRITE_CTRL_BYPASS_EN
        check("load9_rs_busy", 32'(rs_busy), 32'd0);
        check("load9_rs_fwd_valid", 32'(rs_fwd_valid), 32'd1);
        check("load9_rt_fwd_data", rt_fwd_data, 32'h999);
`else
        check("load9_rs_busy", 32'(rs_busy), 32'd1);
`endif
        cycle();
        check("load9_rs_free", 32'(rs_busy), 32'd0);
        check("load9_idle", 32'(reg_write), 32'd0);

        // Output-stage match on register 3
        rs = 5'd3;
        rt = 5'd0;
        push(5'd3, 32'h55);
        drive(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0);
        cycle();
        idle();
`ifdef GPR_WRITE_CTRL_BYPASS_EN
        check("fwd_rs_valid", 32'(rs_fwd_valid), 32'd1);
        check("fwd_rs_data", rs_fwd_data, 32'h55);
        check("fwd_rs_busy", 32'(rs_busy), 32'd0);
        check("fwd_rt_zero", 32'(rt_fwd_valid), 32'd0);
`else
        check("out_rs_busy", 32'(rs_busy), 32'd1);
`endif
        cycle();

        // Reset with three loads queued: nothing queued may ever issue
        for (int i = 0; i < 3; i++) push(5'd23, 32'h301 + 32'(i));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd23, 32'h301 + 32'(i), 1'b1, 5'(24 + i), 32'h2400 + 32'(i));
            cycle();
        end
        check("pre_rst_pending", 32'(pending), 32'd3);
        idle();
        @(negedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_pending", 32'(pending), 32'd0);
        check("mid_rst_reg_write", 32'(reg_write), 32'd0);
        check("mid_rst_mem_ready", 32'(mem_ready), 32'd1);
        cycle();
        cycle();
        reset_n = 1'b1;
        repeat (6) cycle();
        check("after_rst_pending", 32'(pending), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
